// File: rtl/mi_pkg.sv
// Shared definitions for the microprogram sequencer: microword field positions,
// COND encodings and the sequencer FSM state type.
package mi_pkg;

  localparam int CSA_W  = 11;
  localparam int WORD_W = 41;

  localparam int A_MSB     = 40;
  localparam int A_LSB     = 35;
  localparam int AMUX_BIT  = 34;
  localparam int B_MSB     = 33;
  localparam int B_LSB     = 28;
  localparam int BMUX_BIT  = 27;
  localparam int C_MSB     = 26;
  localparam int C_LSB     = 21;
  localparam int CMUX_BIT  = 20;
  localparam int RD_BIT    = 19;
  localparam int WR_BIT    = 18;
  localparam int ALU_MSB   = 17;
  localparam int ALU_LSB   = 14;
  localparam int COND_MSB  = 13;
  localparam int COND_LSB  = 11;
  localparam int JADDR_MSB = 10;
  localparam int JADDR_LSB = 0;

  localparam logic [2:0] COND_NEXT   = 3'd0;
  localparam logic [2:0] COND_N      = 3'd1;
  localparam logic [2:0] COND_Z      = 3'd2;
  localparam logic [2:0] COND_V      = 3'd3;
  localparam logic [2:0] COND_C      = 3'd4;
  localparam logic [2:0] COND_IR13   = 3'd5;
  localparam logic [2:0] COND_JUMP   = 3'd6;
  localparam logic [2:0] COND_DECODE = 3'd7;

  localparam logic DECODE_PREFIX = 1'b1;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MWAIT = 2'd2
  } mi_state_t;

endpackage

// File: rtl/mi_sequencer_if.sv
// ROM / datapath / memory-side signals of the sequencer; master = sequencer.
interface mi_sequencer_if #(
  parameter int ADDR_W = 11,
  parameter int WORD_W = 41
);
  logic [ADDR_W-1:0] CSA_OUT;
  logic [WORD_W-1:0] MIR_IN;
  logic [WORD_W-1:0] MIR_OUT;
  logic [31:0]       IR_IN;
  logic              FLAG_N;
  logic              FLAG_Z;
  logic              FLAG_V;
  logic              FLAG_C;
  logic              MEM_REQ;
  logic              MEM_READY;
  logic              STEP_STROBE;
  logic              MEM_ERR;

  modport master (
    output CSA_OUT, MIR_OUT, MEM_REQ, STEP_STROBE, MEM_ERR,
    input  MIR_IN, IR_IN, FLAG_N, FLAG_Z, FLAG_V, FLAG_C, MEM_READY
  );

  modport slave (
    input  CSA_OUT, MIR_OUT, MEM_REQ, STEP_STROBE, MEM_ERR,
    output MIR_IN, IR_IN, FLAG_N, FLAG_Z, FLAG_V, FLAG_C, MEM_READY
  );
endinterface

// File: rtl/mi_next_addr.sv
// Combinational next control-store address from COND/JADDR, PSR flags and IR.
module mi_next_addr
  import mi_pkg::*;
(
  input  logic [CSA_W-1:0] csar,
  input  logic [2:0]       cond,
  input  logic [CSA_W-1:0] jaddr,
  input  logic             flag_n,
  input  logic             flag_z,
  input  logic             flag_v,
  input  logic             flag_c,
  input  logic [31:0]      ir,
  output logic [CSA_W-1:0] next_addr
);

  logic [CSA_W-1:0] seq_addr;
  logic [CSA_W-1:0] decode_addr;
  logic             unused_ir;

  assign seq_addr    = CSA_W'(csar + 1'b1);
  assign decode_addr = {DECODE_PREFIX, ir[31:30], ir[24:19], 2'b00};
  assign unused_ir   = ^{ir[29:25], ir[18:14], ir[12:0]};

  always_comb begin
    next_addr = seq_addr;
    case (cond)
      COND_NEXT:   next_addr = seq_addr;
      COND_N:      next_addr = flag_n ? jaddr : seq_addr;
      COND_Z:      next_addr = flag_z ? jaddr : seq_addr;
      COND_V:      next_addr = flag_v ? jaddr : seq_addr;
      COND_C:      next_addr = flag_c ? jaddr : seq_addr;
      COND_IR13:   next_addr = ir[13] ? jaddr : seq_addr;
      COND_JUMP:   next_addr = jaddr;
      COND_DECODE: next_addr = decode_addr;
      default:     next_addr = seq_addr;
    endcase
  end

endmodule

// File: rtl/mi_sequencer.sv
// Microprogram sequencer: LOAD -> EXEC (-> MWAIT) -> commit, one STEP_STROBE per microword.
// MI_SEQ_MEMTIMEOUT_EN adds a memory-wait timeout that sets sticky MEM_ERR and restarts at RESET_ADDR.
module mi_sequencer
  import mi_pkg::*;
#(
  parameter int                     DATA_BUS_ADDR  = 11,
  parameter int                     DATA_BUS_WORD  = 41,
  parameter logic [DATA_BUS_ADDR-1:0] RESET_ADDR   = '0,
  parameter int                     TIMEOUT_CYCLES = 255
)(
  input  logic             CLOCK_50,
  input  logic             RESET_InLow,
  mi_sequencer_if.master   bus
);

  logic [DATA_BUS_ADDR-1:0] csar;
  logic [DATA_BUS_WORD-1:0] mir;
  mi_state_t                state;
  logic                     mem_req;
  logic                     mem_op;
  logic                     commit;
  logic [DATA_BUS_ADDR-1:0] next_addr;

  assign mem_op = mir[RD_BIT] | mir[WR_BIT];

  // Commit is combinational so the strobe lands on the MEM_READY cycle itself.
  assign commit = ((state == ST_EXEC)  && (!mem_op || bus.MEM_READY)) ||
                  ((state == ST_MWAIT) && bus.MEM_READY);

  mi_next_addr u_next_addr (
    .csar      (csar),
    .cond      (mir[COND_MSB:COND_LSB]),
    .jaddr     (mir[JADDR_MSB:JADDR_LSB]),
    .flag_n    (bus.FLAG_N),
    .flag_z    (bus.FLAG_Z),
    .flag_v    (bus.FLAG_V),
    .flag_c    (bus.FLAG_C),
    .ir        (bus.IR_IN),
    .next_addr (next_addr)
  );

`ifdef MI_SEQ_MEMTIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt;
  logic       mem_err;
`endif

  always_ff @(posedge CLOCK_50 or negedge RESET_InLow) begin
    if (!RESET_InLow) begin
      csar    <= RESET_ADDR;
      mir     <= '0;
      state   <= ST_LOAD;
      mem_req <= 1'b0;
`ifdef MI_SEQ_MEMTIMEOUT_EN
      wait_cnt <= '0;
      mem_err  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_LOAD: begin
          mir     <= bus.MIR_IN;
          mem_req <= bus.MIR_IN[RD_BIT] | bus.MIR_IN[WR_BIT];
          state   <= ST_EXEC;
        end
        ST_EXEC: begin
          if (commit) begin
            csar    <= next_addr;
            mem_req <= 1'b0;
            state   <= ST_LOAD;
          end else begin
            state <= ST_MWAIT;
`ifdef MI_SEQ_MEMTIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
        ST_MWAIT: begin
          if (commit) begin
            csar    <= next_addr;
            mem_req <= 1'b0;
            state   <= ST_LOAD;
          end
`ifdef MI_SEQ_MEMTIMEOUT_EN
          else if (wait_cnt == WAIT_LAST) begin
            mem_err <= 1'b1;
            mem_req <= 1'b0;
            csar    <= RESET_ADDR;
            state   <= ST_LOAD;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end
        default: begin
          mem_req <= 1'b0;
          state   <= ST_LOAD;
        end
      endcase
    end
  end

  assign bus.CSA_OUT     = csar;
  assign bus.MIR_OUT     = mir;
  assign bus.MEM_REQ     = mem_req;
  assign bus.STEP_STROBE = commit;
`ifdef MI_SEQ_MEMTIMEOUT_EN
  assign bus.MEM_ERR     = mem_err;
`else
  assign bus.MEM_ERR     = 1'b0;
`endif

endmodule

// File: tb/tb_mi_sequencer.sv
// Self-checking bench for mi_sequencer: directed scenarios plus random microwords against a ROM/PC model.
module tb_mi_sequencer;

`ifdef MI_SEQ_MEMTIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   commits = 0;
  int   mon_strobes = 0;
  logic exp_err = 1'b0;
  logic [10:0] model_pc = 11'd0;
  logic [40:0] rom [0:2047];

  mi_sequencer_if #(.ADDR_W(11), .WORD_W(41)) bus ();

  mi_sequencer #(
    .DATA_BUS_ADDR (11),
    .DATA_BUS_WORD (41),
    .RESET_ADDR    (11'd0),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLOCK_50    (clk),
    .RESET_InLow (rst_n),
    .bus         (bus)
  );

  assign bus.MIR_IN = rom[bus.CSA_OUT];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (bus.STEP_STROBE === 1'b1) mon_strobes++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference next address, written from the COND table with plain arithmetic.
  function automatic logic [10:0] ref_next(input logic [10:0] pc, input logic [40:0] w,
                                           input logic [3:0] fl, input logic [31:0] ir);
    int c, j, seq, op, op3;
    bit take;
    c    = int'(w[13:11]);
    j    = int'(w[10:0]);
    seq  = (int'(pc) + 1) % 2048;
    op   = int'(ir[31:30]);
    op3  = int'(ir[24:19]);
    take = 1'b0;
    if (c == 1) take = fl[3];
    if (c == 2) take = fl[2];
    if (c == 3) take = fl[1];
    if (c == 4) take = fl[0];
    if (c == 5) take = ir[13];
    if (c == 6) take = 1'b1;
    if (c == 7) return 11'(1024 + op * 256 + op3 * 4);
    return take ? 11'(j) : 11'(seq);
  endfunction

  function automatic logic [40:0] mk(input bit rd, input bit wr, input int cond, input int jaddr);
    logic [40:0] w;
    w = {$urandom, $urandom};
    w[19] = rd;
    w[18] = wr;
    w[13:11] = 3'(cond);
    w[10:0] = 11'(jaddr);
    return w;
  endfunction

  // Runs one microinstruction from LOAD; ready arrives dly cycles after EXEC entry.
  task automatic exec_one(input logic [40:0] w, input logic [3:0] fl, input logic [31:0] ir,
                          input int dly, output int req_cyc, output int strobes);
    bit memop;
    req_cyc = 0;
    strobes = 0;
    rom[model_pc] = w;
    {bus.FLAG_N, bus.FLAG_Z, bus.FLAG_V, bus.FLAG_C} = fl;
    bus.IR_IN = ir;
    bus.MEM_READY = 1'b1;
    #1;
    check("load_csa", 64'(bus.CSA_OUT), 64'(model_pc));
    check("load_strobe", 64'(bus.STEP_STROBE), 64'd0);
    @(posedge clk); @(negedge clk);
    memop = w[19] | w[18];
    bus.MEM_READY = memop && (dly == 0);
    #1;
    check("exec_mir", 64'(bus.MIR_OUT), 64'(w));
    if (!memop) begin
      check("exec_req", 64'(bus.MEM_REQ), 64'd0);
      check("exec_strobe", 64'(bus.STEP_STROBE), 64'd1);
      strobes += int'(bus.STEP_STROBE);
    end else begin
      for (int k = 0; k <= dly; k++) begin
        if (k > 0) begin
          @(posedge clk); @(negedge clk);
          bus.MEM_READY = (k == dly);
          #1;
        end
        check("wait_req", 64'(bus.MEM_REQ), 64'd1);
        check("wait_mir", 64'(bus.MIR_OUT), 64'(w));
        check("wait_strobe", 64'(bus.STEP_STROBE), 64'(k == dly));
        req_cyc += int'(bus.MEM_REQ);
        strobes += int'(bus.STEP_STROBE);
      end
    end
    model_pc = ref_next(model_pc, w, fl, ir);
    commits++;
    @(posedge clk); @(negedge clk);
    bus.MEM_READY = 1'b0;
    #1;
    check("post_csa", 64'(bus.CSA_OUT), 64'(model_pc));
    check("post_req", 64'(bus.MEM_REQ), 64'd0);
    check("post_strobe", 64'(bus.STEP_STROBE), 64'd0);
    check("mem_err", 64'(bus.MEM_ERR), 64'(exp_err));
  endtask

  initial begin
    int rq, st, n, mw_dly;
    logic [31:0] ir_a;
    for (int i = 0; i < 2048; i++) rom[i] = '0;
    bus.IR_IN = '0;
    bus.FLAG_N = 1'b0; bus.FLAG_Z = 1'b0; bus.FLAG_V = 1'b0; bus.FLAG_C = 1'b0;
    bus.MEM_READY = 1'b0;
    rst_n = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_csa", 64'(bus.CSA_OUT), 64'd0);
    check("rst_mir", 64'(bus.MIR_OUT), 64'd0);
    check("rst_req", 64'(bus.MEM_REQ), 64'd0);
    check("rst_strobe", 64'(bus.STEP_STROBE), 64'd0);
    check("rst_err", 64'(bus.MEM_ERR), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Address 0, plain sequential microword
    exec_one(41'd0, 4'b0000, 32'd0, 0, rq, st);
    check("first_strobes", 64'(st), 64'd1);
    check("first_csa", 64'(bus.CSA_OUT), 64'd1);

    // Decode dispatch
    ir_a = 32'h8000_0000 | (32'(6'b010000) << 19);
    exec_one(mk(0, 0, 7, 0), 4'b0000, ir_a, 0, rq, st);
    check("decode_1600", 64'(bus.CSA_OUT), 64'd1600);
    ir_a = 32'h8000_0000 | (32'(6'b010110) << 19);
    exec_one(mk(0, 0, 7, 0), 4'b1111, ir_a, 0, rq, st);
    check("decode_1624", 64'(bus.CSA_OUT), 64'd1624);

    // Branch on Z
    exec_one(mk(0, 0, 6, 8), 4'b0000, 32'd0, 0, rq, st);
    exec_one(mk(0, 0, 2, 12), 4'b1011, 32'd0, 0, rq, st);
    check("bz_not_taken", 64'(bus.CSA_OUT), 64'd9);
    exec_one(mk(0, 0, 2, 12), 4'b0100, 32'd0, 0, rq, st);
    check("bz_taken", 64'(bus.CSA_OUT), 64'd12);

    // Memory wait; illegal RD=WR=1 behaves as a read
    mw_dly = (TO >= 6) ? 5 : TO;
    exec_one(mk(1, 0, 0, 0), 4'b0000, 32'd0, mw_dly, rq, st);
    check("mwait_req_cycles", 64'(rq), 64'(mw_dly + 1));
    check("mwait_strobes", 64'(st), 64'd1);
    exec_one(mk(1, 1, 0, 0), 4'b0000, 32'd0, 2, rq, st);
    check("rdwr_req_cycles", 64'(rq), 64'd3);

    // Wrap at 2047
    exec_one(mk(0, 0, 6, 2047), 4'b0000, 32'd0, 0, rq, st);
    exec_one(mk(0, 0, 0, 5), 4'b0000, 32'd0, 0, rq, st);
    check("wrap_csa", 64'(bus.CSA_OUT), 64'd0);

    // Reset during MWAIT
    exec_one(mk(0, 0, 6, 300), 4'b0000, 32'd0, 0, rq, st);
    rom[model_pc] = mk(1, 0, 6, 77);
    bus.MEM_READY = 1'b0;
    n = mon_strobes;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    #1;
    check("pre_rst_req", 64'(bus.MEM_REQ), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_req", 64'(bus.MEM_REQ), 64'd0);
    check("midrst_csa", 64'(bus.CSA_OUT), 64'd0);
    check("midrst_strobe", 64'(bus.STEP_STROBE), 64'd0);
    check("midrst_mir", 64'(bus.MIR_OUT), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_no_commit", 64'(mon_strobes), 64'(n));
    model_pc = 11'd0;

`ifdef MI_SEQ_MEMTIMEOUT_EN
    // Timeout with MEM_READY held low
    rom[model_pc] = mk(1, 0, 6, 100);
    n = mon_strobes;
    @(posedge clk); @(negedge clk);
    st = 0;
    while (st < 20 && bus.MEM_ERR !== 1'b1) begin
      @(posedge clk); @(negedge clk);
      st++;
    end
    #1;
    check("timeout_cycles", 64'(st), 64'(TO + 1));
    check("timeout_err", 64'(bus.MEM_ERR), 64'd1);
    check("timeout_csa", 64'(bus.CSA_OUT), 64'd0);
    check("timeout_req", 64'(bus.MEM_REQ), 64'd0);
    check("timeout_no_strobe", 64'(mon_strobes), 64'(n));
    exp_err = 1'b1;
    model_pc = 11'd0;
`else
    exec_one(mk(0, 1, 0, 0), 4'b0000, 32'd0, 12, rq, st);
    check("long_wait_strobes", 64'(st), 64'd1);
`endif

    // Random microwords, flags, IR and memory latency
    for (int i = 0; i < 150; i++) begin
      int r;
      logic [40:0] w;
      r = $urandom_range(0, 3);
      w = mk(r == 1 || r == 3, r == 2 || r == 3, $urandom_range(0, 7), $urandom_range(0, 2047));
      exec_one(w, 4'($urandom), $urandom, $urandom_range(0, 4), rq, st);
      check("rand_strobes", 64'(st), 64'd1);
    end

    @(negedge clk);
    check("total_strobes", 64'(mon_strobes), 64'(commits));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
